cc_pair_scheduler: RTL and testbench

Time-multiplexes the single cross-correlation (CC) engine across NUM_PAIRS hydrophone channel pairs (reference channel vs. channel k), then packs the per-pair lag results into one UART frame. It sits between the pipeline controller's CC start pulse and the CC block/UART TX. It drives the ring-buffer pair-select mux and guards each CC run with a watchdog.

---
 rtl/cc_sched_pkg.sv | 23 ++
 rtl/cc_watchdog.sv | 36 +++
 rtl/cc_pair_scheduler.sv | 161 ++++++++++++++++
 tb/tb_cc_pair_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cc_sched_pkg
// Brief   : Shared state encoding and frame constants for the CC pair scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package cc_sched_pkg;

    localparam int         PAIR_SEL_W  = 2;
    localparam logic [3:0] HDR_NIBBLE  = 4'hA;
    localparam logic [7:0] TIMEOUT_IDX = 8'hFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_LAUNCH  = 3'd2;
    localparam state_t ST_WAIT_CC = 3'd3;
    localparam state_t ST_SEND    = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/cc_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : cc_watchdog
// Brief   : Clear/enable up-counter that flags the last permitted CC cycle.
// Revision: 1.0 - initial release
// ============================================================================
module cc_watchdog #(
    parameter int WDOG_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset_b,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int c_cnt_w = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_terminal = c_cnt_w'(WDOG_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    assign tc = en && (r_count == c_terminal);

    // Holds at terminal so a stuck enable never wraps into a false early expiry.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !tc) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cc_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : cc_pair_scheduler
// Brief   : Sequences the shared CC engine over channel pairs and emits the
//           per-pair lag results as one checksummed UART frame.
// Revision: 1.0 - initial release
// ============================================================================
module cc_pair_scheduler
    import cc_sched_pkg::*;
#(
    parameter int NUM_PAIRS   = 3,
    parameter int IDX_W       = 8,
    parameter int WDOG_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cc_done,
    input  logic [IDX_W-1:0]      max_index,
    input  logic                  tx_ready,
    output logic [PAIR_SEL_W-1:0] pair_sel,
    output logic                  cc_start,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            err_flags
);

    state_t     r_state;
    logic [2:0] r_byte_cnt;
    logic [7:0] r_csum;
    logic [7:0] r_result [4];

    logic       w_wdog_tc;
    logic       w_wdog_clr;
    logic       w_wdog_en;
    logic       w_last_pair;
    logic [7:0] w_idx_byte;
    logic [3:0] w_err_next;
    logic [7:0] w_next_byte;

    assign w_wdog_clr  = (r_state == ST_LAUNCH);
    assign w_wdog_en   = (r_state == ST_WAIT_CC);
    assign w_last_pair = (pair_sel == PAIR_SEL_W'(NUM_PAIRS - 1));
    assign w_idx_byte  = 8'(max_index);

    cc_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_b (reset_b),
        .clr     (w_wdog_clr),
        .en      (w_wdog_en),
        .tc      (w_wdog_tc)
    );

    // Header is built from the post-update flags so a timeout on the last pair
    // still shows up in the frame it belongs to.
    always_comb begin
        w_err_next = err_flags;
        if ((r_state == ST_WAIT_CC) && w_wdog_tc && !cc_done) begin
            w_err_next[pair_sel] = 1'b1;
        end
    end

    always_comb begin
        w_next_byte = r_result[r_byte_cnt[1:0]];
        if (r_byte_cnt == 3'(NUM_PAIRS)) begin
            w_next_byte = r_csum ^ tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_result[i] <= '0;
            end
            pair_sel   <= '0;
            cc_start   <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_flags  <= '0;
        end else begin
            cc_start <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                r_state  <= ST_IDLE;
                pair_sel <= '0;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            err_flags <= '0;
                            for (int i = 0; i < 4; i++) begin
                                r_result[i] <= '0;
                            end
                            pair_sel <= '0;
                            busy     <= 1'b1;
                            r_state  <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        cc_start <= 1'b1;
                        r_state  <= ST_LAUNCH;
                    end
                    ST_LAUNCH: begin
                        r_state <= ST_WAIT_CC;
                    end
                    ST_WAIT_CC: begin
                        if (cc_done || w_wdog_tc) begin
                            r_result[pair_sel] <= cc_done ? w_idx_byte : TIMEOUT_IDX;
                            err_flags          <= w_err_next;
                            if (w_last_pair) begin
                                tx_valid   <= 1'b1;
                                tx_data    <= {HDR_NIBBLE, w_err_next};
                                r_byte_cnt <= '0;
                                r_csum     <= '0;
                                r_state    <= ST_SEND;
                            end else begin
                                pair_sel <= pair_sel + PAIR_SEL_W'(1);
                                r_state  <= ST_SETUP;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (tx_ready) begin
                            r_csum <= r_csum ^ tx_data;
                            if (r_byte_cnt == 3'(NUM_PAIRS + 1)) begin
                                tx_valid <= 1'b0;
                                done     <= 1'b1;
                                r_state  <= ST_DONE;
                            end else begin
                                tx_data    <= w_next_byte;
                                r_byte_cnt <= r_byte_cnt + 3'd1;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cc_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_cc_pair_scheduler
// Brief   : Directed, table-driven self-checking bench for cc_pair_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cc_pair_scheduler;

    typedef struct {
        logic [2:0][7:0] idx;
        logic [2:0]      to_mask;
        bit              toggle;
        logic [4:0][7:0] exp_frame;
        logic [3:0]      exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cc_done = 1'b0;
    logic [7:0] max_index = 8'h00;
    logic       tx_ready = 1'b0;
    logic [1:0] pair_sel;
    logic       cc_start;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [3:0] err_flags;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [5];

    cc_pair_scheduler #(
        .NUM_PAIRS   (3),
        .IDX_W       (8),
        .WDOG_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .start     (start),
        .abort     (abort),
        .cc_done   (cc_done),
        .max_index (max_index),
        .tx_ready  (tx_ready),
        .pair_sel  (pair_sel),
        .cc_start  (cc_start),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulses (start, cc_done) are dropped after one cycle; optional stale cc_done in SETUP.
    task automatic wait_cc_start(input bit stale, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
            start   = 1'b0;
            cc_done = stale && (lat == 1);
        end while (!cc_start && lat < 60);
        cc_done = 1'b0;
    endtask

    task automatic wait_tx_valid(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
            start   = 1'b0;
            cc_done = 1'b0;
        end while (!tx_valid && lat < 60);
    endtask

    task automatic drive_pairs(input int vi, input bit noise);
        int lat;
        int exp_lat;
        bit stale;
        vec_t v;
        v       = vecs[vi];
        start   = 1'b1;
        exp_lat = 2;
        stale   = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_cc_start(stale, lat);
            check($sformatf("v%0d_cc_start_p%0d", vi, p), cc_start, 1);
            check($sformatf("v%0d_cc_lat_p%0d", vi, p), lat, exp_lat);
            check($sformatf("v%0d_pair_sel_p%0d", vi, p), pair_sel, p);
            if (!v.to_mask[p]) begin
                step();
                start = noise;
                step();
                start     = 1'b0;
                cc_done   = 1'b1;
                max_index = v.idx[p];
                exp_lat   = 2;
                stale     = noise;
            end else begin
                exp_lat = 18;
                stale   = 1'b0;
            end
        end
        wait_tx_valid(lat);
        check($sformatf("v%0d_tx_lat", vi), lat, v.to_mask[2] ? 17 : 1);
    endtask

    task automatic run_pass(input int vi, input bit noise);
        logic [7:0] got [5];
        logic [7:0] prev_data;
        bit         prev_stall;
        bit         rdy;
        int         nb;
        int         cyc;
        vec_t       v;
        v = vecs[vi];
        drive_pairs(vi, noise);
        nb = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        for (int i = 0; i < 5; i++) got[i] = 8'h00;
        while (nb < 5 && cyc < 40) begin
            check($sformatf("v%0d_tx_valid_c%0d", vi, cyc), tx_valid, 1);
            if (prev_stall) check($sformatf("v%0d_hold_c%0d", vi, cyc), tx_data, prev_data);
            rdy      = v.toggle ? (cyc % 2 == 0) : 1'b1;
            tx_ready = rdy;
            start    = noise && (cyc == 1);
            if (rdy) begin
                got[nb] = tx_data;
                nb++;
            end
            prev_stall = !rdy;
            prev_data  = tx_data;
            step();
            cyc++;
        end
        start = 1'b0;
        check($sformatf("v%0d_bytes", vi), nb, 5);
        check($sformatf("v%0d_send_cycles", vi), cyc, v.toggle ? 9 : 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("v%0d_byte%0d", vi, i), got[i], v.exp_frame[i]);
        end
        check($sformatf("v%0d_done", vi), done, 1);
        check($sformatf("v%0d_valid_after", vi), tx_valid, 0);
        check($sformatf("v%0d_err", vi), err_flags, v.exp_err);
        step();
        check($sformatf("v%0d_done_low", vi), done, 0);
        check($sformatf("v%0d_idle", vi), busy, 0);
        check($sformatf("v%0d_err_held", vi), err_flags, v.exp_err);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0].idx = {8'h56, 8'h34, 8'h12}; vecs[0].to_mask = 3'b000; vecs[0].toggle = 1'b0;
        vecs[0].exp_frame = {8'hD0, 8'h56, 8'h34, 8'h12, 8'hA0}; vecs[0].exp_err = 4'h0;
        vecs[1].idx = {8'h56, 8'h34, 8'h12}; vecs[1].to_mask = 3'b010; vecs[1].toggle = 1'b0;
        vecs[1].exp_frame = {8'h19, 8'h56, 8'hFF, 8'h12, 8'hA2}; vecs[1].exp_err = 4'h2;
        vecs[2].idx = {8'h03, 8'h02, 8'h01}; vecs[2].to_mask = 3'b000; vecs[2].toggle = 1'b1;
        vecs[2].exp_frame = {8'hA0, 8'h03, 8'h02, 8'h01, 8'hA0}; vecs[2].exp_err = 4'h0;
        vecs[3].idx = {8'h00, 8'h00, 8'h00}; vecs[3].to_mask = 3'b111; vecs[3].toggle = 1'b0;
        vecs[3].exp_frame = {8'h58, 8'hFF, 8'hFF, 8'hFF, 8'hA7}; vecs[3].exp_err = 4'h7;
        vecs[4].idx = {8'h80, 8'h00, 8'h7F}; vecs[4].to_mask = 3'b101; vecs[4].toggle = 1'b1;
        vecs[4].exp_frame = {8'hA5, 8'hFF, 8'h00, 8'hFF, 8'hA5}; vecs[4].exp_err = 4'h5;

        step();
        step();
        check("rst_pair_sel", pair_sel, 0);
        check("rst_cc_start", cc_start, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_flags, 0);
        reset_b = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_pass(i, 1'b0);
        end

        // Spurious start pulses and stale cc_done must leave the frame unchanged.
        run_pass(0, 1'b1);

        // Abort in pair 1 WAIT_CC after pair 0 timed out.
        start = 1'b1;
        wait_cc_start(1'b0, lat);
        wait_cc_start(1'b0, lat);
        check("abort_pre_pair", pair_sel, 1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_pair_sel", pair_sel, 0);
        check("abort_err_kept", err_flags, 1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (tx_valid || done || cc_start) seen++;
            step();
        end
        check("abort_quiet", seen, 0);
        run_pass(0, 1'b0);

        // Asynchronous reset in the middle of SEND.
        drive_pairs(1, 1'b0);
        tx_ready = 1'b1;
        step();
        step();
        #2 reset_b = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err_flags, 0);
        check("arst_pair_sel", pair_sel, 0);
        step();
        reset_b = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy || cc_start || tx_valid || done) seen++;
        end
        check("arst_idle", seen, 0);
        run_pass(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
